// File: rtl/viterbi_arb_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | viterbi_arb_pkg: shared FSM encoding, default widths and helpers  |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
package viterbi_arb_pkg;

  localparam int DEF_LENIN   = 10;
  localparam int DEF_LENOUT  = 5;
  localparam int DEF_STATE_W = 16;
  localparam int RUN_CNT_W   = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_RESP = 2'd3
  } arb_state_t;

  function automatic int wrap_idx(input int base, input int off, input int n);
    return (base + off) % n;
  endfunction

endpackage
`default_nettype wire

// File: rtl/viterbi_arbiter_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | viterbi_arbiter_if: request, response and decoder-core signals    |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
interface viterbi_arbiter_if #(
  parameter int N_REQ   = 4,
  parameter int LENIN   = 10,
  parameter int LENOUT  = 5,
  parameter int STATE_W = 16
);
  localparam int ID_W = $clog2(N_REQ);

  logic [N_REQ-1:0]       req_valid;
  logic [N_REQ-1:0]       req_ready;
  logic [N_REQ*LENIN-1:0] req_code;
  logic [STATE_W-1:0]     cfg_state;
  logic                   resp_valid;
  logic                   resp_ready;
  logic [LENOUT-1:0]      resp_data;
  logic [ID_W-1:0]        resp_id;
  logic                   resp_err;
  logic                   busy;
  logic                   dec_rst_n;
  logic [LENIN-1:0]       dec_codein;
  logic [STATE_W-1:0]     dec_state_out;
  logic [LENOUT-1:0]      dec_codeout;
  logic                   dec_finish;

  // Environment side: requesters, response sink and the decoder core.
  modport master (
    output req_valid, req_code, cfg_state, resp_ready, dec_codeout, dec_finish,
    input  req_ready, resp_valid, resp_data, resp_id, resp_err, busy,
           dec_rst_n, dec_codein, dec_state_out
  );

  modport slave (
    input  req_valid, req_code, cfg_state, resp_ready, dec_codeout, dec_finish,
    output req_ready, resp_valid, resp_data, resp_id, resp_err, busy,
           dec_rst_n, dec_codein, dec_state_out
  );
endinterface
`default_nettype wire

// File: rtl/viterbi_arbiter_rr_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | rr_arbiter: combinational round-robin grant starting at rr_ptr    |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
module rr_arbiter
  import viterbi_arb_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int ID_W  = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req_valid,
  input  logic [ID_W-1:0]  rr_ptr,
  output logic [N_REQ-1:0] grant,
  output logic [ID_W-1:0]  grant_idx,
  output logic             any_valid
);

  int w_idx;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any_valid = 1'b0;
    w_idx     = 0;
    for (int i = 0; i < N_REQ; i++) begin
      w_idx = wrap_idx(int'(rr_ptr), i, N_REQ);
      if (!any_valid && req_valid[w_idx]) begin
        any_valid    = 1'b1;
        grant[w_idx] = 1'b1;
        grant_idx    = ID_W'(w_idx);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/viterbi_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | viterbi_arbiter: shares one Viterbi core among N_REQ requesters.  |
// | Optional RUN timeout: define VITERBI_ARB_TIMEOUT_EN. Rev 1.0      |
// +------------------------------------------------------------------+
module viterbi_arbiter
  import viterbi_arb_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int LENIN   = DEF_LENIN,
  parameter int LENOUT  = DEF_LENOUT,
  parameter int STATE_W = DEF_STATE_W,
  parameter int TIMEOUT = 63
) (
  input  logic              clk,
  input  logic              rst,
  viterbi_arbiter_if.slave  bus
);

  localparam int ID_W = $clog2(N_REQ);

  if (N_REQ < 2 || N_REQ > 8) begin : g_bad_n_req
    $error("viterbi_arbiter: N_REQ must be 2..8");
  end
  if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
    $error("viterbi_arbiter: TIMEOUT must be 1..255");
  end

  arb_state_t         r_state;
  logic [ID_W-1:0]    r_rr_ptr;
  logic [ID_W-1:0]    r_id;
  logic [LENIN-1:0]   r_codein;
  logic [STATE_W-1:0] r_state_out;
  logic [LENOUT-1:0]  r_resp_data;
  logic               r_resp_err;
  logic               r_resp_valid;
  logic               r_dec_rst_n;

  logic [N_REQ-1:0]   w_grant;
  logic [ID_W-1:0]    w_grant_idx;
  logic               w_any;
  logic               w_accept;

  rr_arbiter #(.N_REQ(N_REQ), .ID_W(ID_W)) u_rr_arbiter (
    .req_valid (bus.req_valid),
    .rr_ptr    (r_rr_ptr),
    .grant     (w_grant),
    .grant_idx (w_grant_idx),
    .any_valid (w_any)
  );

  assign w_accept      = (r_state == ST_IDLE) && w_any;
  assign bus.req_ready = (r_state == ST_IDLE) ? w_grant : '0;

`ifdef VITERBI_ARB_TIMEOUT_EN
  logic [RUN_CNT_W-1:0] r_run_cnt;
  logic                 w_timeout;

  assign w_timeout = (r_run_cnt == RUN_CNT_W'(TIMEOUT));

  // RUN is always left at TIMEOUT, so the counter cannot wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_run_cnt <= '0;
    end else if (r_state == ST_LOAD) begin
      r_run_cnt <= '0;
    end else if (r_state == ST_RUN) begin
      r_run_cnt <= r_run_cnt + 1'b1;
    end
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_rr_ptr     <= '0;
      r_id         <= '0;
      r_codein     <= '0;
      r_state_out  <= '0;
      r_resp_data  <= '0;
      r_resp_err   <= 1'b0;
      r_resp_valid <= 1'b0;
      r_dec_rst_n  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_codein    <= bus.req_code[int'(w_grant_idx)*LENIN +: LENIN];
            r_state_out <= bus.cfg_state;
            r_id        <= w_grant_idx;
            r_state     <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          r_dec_rst_n <= 1'b1;
          r_state     <= ST_RUN;
        end
        ST_RUN: begin
          // Finish takes priority over a timeout in the same cycle.
          if (bus.dec_finish) begin
            r_resp_data  <= bus.dec_codeout;
            r_resp_err   <= 1'b0;
            r_resp_valid <= 1'b1;
            r_dec_rst_n  <= 1'b0;
            r_state      <= ST_RESP;
          end
`ifdef VITERBI_ARB_TIMEOUT_EN
          else if (w_timeout) begin
            r_resp_data  <= '0;
            r_resp_err   <= 1'b1;
            r_resp_valid <= 1'b1;
            r_dec_rst_n  <= 1'b0;
            r_state      <= ST_RESP;
          end
`endif
        end
        ST_RESP: begin
          if (bus.resp_ready) begin
            r_resp_valid <= 1'b0;
            r_rr_ptr     <= ID_W'(wrap_idx(int'(r_id), 1, N_REQ));
            r_state      <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.busy          = (r_state != ST_IDLE);
  assign bus.resp_valid    = r_resp_valid;
  assign bus.resp_data     = r_resp_data;
  assign bus.resp_id       = r_id;
  assign bus.resp_err      = r_resp_err;
  assign bus.dec_rst_n     = r_dec_rst_n;
  assign bus.dec_codein    = r_codein;
  assign bus.dec_state_out = r_state_out;

endmodule
`default_nettype wire

// File: tb/tb_viterbi_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_viterbi_arbiter: job table, stub decoder core and scoreboard   |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
module tb_viterbi_arbiter;

  localparam int N  = 4;
  localparam int LI = 10;
  localparam int LO = 5;
  localparam int SW = 16;
  localparam int TO = 63;

  typedef struct {
    logic [N-1:0] mask;
    int           exp_id;
    int           delay;      // finish this many cycles after dec_rst_n rises; -1 = never
    int           hold;       // cycles of resp_ready low
    bit           fin_in_load;
    bit           exp_err;
  } vec_t;

  typedef struct {
    int            id;
    logic [LO-1:0] data;
    bit            err;
    logic [LI-1:0] code;
    logic [SW-1:0] cfg;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  viterbi_arbiter_if #(.N_REQ(N), .LENIN(LI), .LENOUT(LO), .STATE_W(SW)) bus ();

  viterbi_arbiter #(.N_REQ(N), .LENIN(LI), .LENOUT(LO), .STATE_W(SW), .TIMEOUT(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Stub decoder core: result is a fixed function of its code input.
  function automatic logic [LO-1:0] core_fn(input logic [LI-1:0] c);
    return c[9:5] ^ c[4:0] ^ 5'b00001;
  endfunction

  int   stub_delay = 0;
  int   stub_cnt   = 0;
  logic stub_force = 1'b0;

  always @(posedge clk) begin
    if (!bus.dec_rst_n) stub_cnt <= 0;
    else                stub_cnt <= stub_cnt + 1;
  end

  assign bus.dec_finish  = stub_force | (bus.dec_rst_n && stub_delay >= 0 && stub_cnt == stub_delay);
  assign bus.dec_codeout = core_fn(bus.dec_codein);

  int   n_checks = 0;
  int   n_pass   = 0;
  exp_t sb[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  function automatic vec_t mk(input logic [N-1:0] mask, input int id, input int delay,
                              input int hold, input bit fil, input bit err);
    vec_t v;
    v.mask = mask; v.exp_id = id; v.delay = delay;
    v.hold = hold; v.fin_in_load = fil; v.exp_err = err;
    return v;
  endfunction

  task automatic run_job(input vec_t v, input int vi);
    logic [LI-1:0] codes [N];
    logic [N-1:0]  exp_g;
    logic [LO-1:0] d0;
    logic [31:0]   id0;
    exp_t e, got;
    int w, lat, exp_lat;

    for (int i = 0; i < N; i++) begin
      codes[i] = LI'($urandom);
      bus.req_code[i*LI +: LI] = codes[i];
    end
    if (vi == 0) begin
      codes[2] = 10'b1110001011;
      bus.req_code[2*LI +: LI] = codes[2];
    end
    bus.cfg_state = SW'($urandom);
    bus.req_valid = v.mask;
    stub_delay    = v.delay;
    exp_g         = '0;
    exp_g[v.exp_id] = 1'b1;
    #1;
    w = 0;
    while (bus.req_ready == '0 && w < 20) begin
      @(negedge clk); #1; w++;
    end
    check($sformatf("v%0d grant", vi), 32'(bus.req_ready), 32'(exp_g));
    check($sformatf("v%0d accept_wait", vi), w, 0);
    if (bus.req_ready == '0) return;

    e.id   = v.exp_id;
    e.err  = v.exp_err;
    e.data = v.exp_err ? '0 : core_fn(codes[v.exp_id]);
    e.code = codes[v.exp_id];
    e.cfg  = bus.cfg_state;
    sb.push_back(e);
    exp_lat = 3 + (v.exp_err ? TO : v.delay);

    @(posedge clk);
    #1;
    bus.req_code  = ~bus.req_code;
    bus.cfg_state = ~bus.cfg_state;
    @(negedge clk);
    check($sformatf("v%0d load_codein", vi), 32'(bus.dec_codein), 32'(e.code));
    check($sformatf("v%0d load_rst_n", vi), 32'(bus.dec_rst_n), 0);
    if (v.fin_in_load) stub_force = 1'b1;
    @(negedge clk);
    stub_force = 1'b0;
    check($sformatf("v%0d run_rst_n", vi), 32'(bus.dec_rst_n), 1);

    lat = 2;
    while (!bus.resp_valid && lat < 400) begin
      @(negedge clk); lat++;
    end
    check($sformatf("v%0d latency", vi), lat, exp_lat);

    d0  = bus.resp_data;
    id0 = 32'(bus.resp_id);
    for (int h = 0; h < v.hold; h++) begin
      @(negedge clk);
      check($sformatf("v%0d hold_valid", vi), 32'(bus.resp_valid), 1);
      check($sformatf("v%0d hold_data", vi), 32'(bus.resp_data), 32'(d0));
      check($sformatf("v%0d hold_id", vi), 32'(bus.resp_id), id0);
      check($sformatf("v%0d hold_ready", vi), 32'(bus.req_ready), 0);
    end

    got = sb.pop_front();
    check($sformatf("v%0d resp_data", vi), 32'(bus.resp_data), 32'(got.data));
    check($sformatf("v%0d resp_id", vi), 32'(bus.resp_id), got.id);
    check($sformatf("v%0d resp_err", vi), 32'(bus.resp_err), 32'(got.err));
    check($sformatf("v%0d resp_codein", vi), 32'(bus.dec_codein), 32'(got.code));
    check($sformatf("v%0d resp_state", vi), 32'(bus.dec_state_out), 32'(got.cfg));
    bus.resp_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.resp_ready = 1'b0;
  endtask

  initial begin
    vec_t vecs[$];

    bus.req_valid  = '0;
    bus.req_code   = '0;
    bus.cfg_state  = '0;
    bus.resp_ready = 1'b0;

    // rr_ptr trace: 0 -> 3 -> 0 -> 1 -> 2 -> 3 -> 0 -> 2 -> 0 -> 1 -> 0 -> 2
    vecs.push_back(mk(4'b0100, 2, 27, 10, 1'b0, 1'b0));
    vecs.push_back(mk(4'b1111, 3,  0,  0, 1'b0, 1'b0));
    vecs.push_back(mk(4'b1111, 0,  1,  0, 1'b0, 1'b0));
    vecs.push_back(mk(4'b1111, 1,  2,  0, 1'b0, 1'b0));
    vecs.push_back(mk(4'b1111, 2,  3,  0, 1'b0, 1'b0));
    vecs.push_back(mk(4'b1111, 3,  4,  0, 1'b0, 1'b0));
    vecs.push_back(mk(4'b1010, 1,  5,  0, 1'b0, 1'b0));
    vecs.push_back(mk(4'b1010, 3,  2,  0, 1'b0, 1'b0));
    vecs.push_back(mk(4'b0001, 0,  5,  0, 1'b1, 1'b0));
    vecs.push_back(mk(4'b1001, 3,  1,  0, 1'b0, 1'b0));
    vecs.push_back(mk(4'b0110, 1,  6,  2, 1'b0, 1'b0));
`ifdef VITERBI_ARB_TIMEOUT_EN
    vecs.push_back(mk(4'b0001, 0, -1,  3, 1'b0, 1'b1));
    vecs.push_back(mk(4'b0001, 0,  4,  0, 1'b0, 1'b0));
    vecs.push_back(mk(4'b0100, 2, TO,  0, 1'b0, 1'b0));
`endif

    repeat (2) @(negedge clk);
    check("rst req_ready",  32'(bus.req_ready), 0);
    check("rst resp_valid", 32'(bus.resp_valid), 0);
    check("rst resp_data",  32'(bus.resp_data), 0);
    check("rst resp_id",    32'(bus.resp_id), 0);
    check("rst resp_err",   32'(bus.resp_err), 0);
    check("rst busy",       32'(bus.busy), 0);
    check("rst dec_rst_n",  32'(bus.dec_rst_n), 0);
    check("rst codein",     32'(bus.dec_codein), 0);
    check("rst state_out",  32'(bus.dec_state_out), 0);
    rst = 1'b0;
    @(negedge clk);

    // Finish pulse while idle must be ignored.
    stub_force = 1'b1;
    repeat (2) @(negedge clk);
    stub_force = 1'b0;
    @(negedge clk);
    check("idle_fin resp_valid", 32'(bus.resp_valid), 0);
    check("idle_fin busy",       32'(bus.busy), 0);

    foreach (vecs[i]) run_job(vecs[i], i);

    // Reset in RUN drops the job; first grant afterwards goes to requester 0.
    stub_delay    = 200;
    bus.req_valid = 4'b0010;
    @(posedge clk);
    repeat (5) @(negedge clk);
    check("midrst pre busy", 32'(bus.busy), 1);
    rst = 1'b1;
    bus.req_valid = '0;
    #1;
    check("midrst dec_rst_n",  32'(bus.dec_rst_n), 0);
    check("midrst resp_valid", 32'(bus.resp_valid), 0);
    check("midrst busy",       32'(bus.busy), 0);
    check("midrst resp_id",    32'(bus.resp_id), 0);
    check("midrst codein",     32'(bus.dec_codein), 0);
    check("midrst state_out",  32'(bus.dec_state_out), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("postrst resp_valid", 32'(bus.resp_valid), 0);
    bus.req_valid = 4'b1111;
    #1;
    check("postrst grant", 32'(bus.req_ready), 32'h1);
    run_job(mk(4'b1111, 0, 3, 0, 1'b0, 1'b0), 99);

    check("sb_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
